// File: rtl/state_sequencer.sv
// Upstream state sequencer for the oscillator configuration stage.
// Optional SEQ_AUTOCYCLE_EN adds auto_en for timed round-robin cycling.
module state_sequencer #(
  parameter int DWELL_TICKS = 4000,
  parameter int CNT_W       = 16,
  parameter int NUM_STATES  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       req_valid,
  input  logic [2:0] req_state,
`ifdef SEQ_AUTOCYCLE_EN
  input  logic       auto_en,
`endif
  output logic       req_ready,
  output logic [2:0] state_select,
  output logic       state_changed,
  output logic       req_rejected,
  output logic       dwell_active
);

  typedef enum logic {IDLE, DWELL} fsm_t;

  localparam logic [3:0] NS = 4'(NUM_STATES);
  localparam logic [CNT_W-1:0] DW = CNT_W'(DWELL_TICKS);

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             legal;
  logic             auto_go;
  logic             change;
  logic [2:0]       new_sel;

  assign xfer  = req_valid && req_ready;
  assign legal = {1'b0, req_state} < NS;

`ifdef SEQ_AUTOCYCLE_EN
  localparam logic [2:0] LAST = 3'(NUM_STATES - 1);
  logic [2:0] nxt_auto;
  assign nxt_auto = (state_select == LAST) ? 3'd0 : state_select + 3'd1;
  assign auto_go  = (fsm == IDLE) && auto_en && !req_valid && clk_en;
  assign new_sel  = xfer ? req_state : nxt_auto;
`else
  assign auto_go  = 1'b0;
  assign new_sel  = req_state;
`endif

  // A handshake always wins; auto_go already excludes req_valid.
  assign change = (xfer && legal && (req_state != state_select)) || auto_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      state_select  <= 3'd0;
      state_changed <= 1'b0;
      req_rejected  <= 1'b0;
      dwell_active  <= 1'b0;
    end else begin
      state_changed <= 1'b0;
      req_rejected  <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (xfer && !legal) begin
            req_rejected <= 1'b1;
          end else if (change) begin
            state_select  <= new_sel;
            state_changed <= 1'b1;
            if (DWELL_TICKS != 0) begin
              fsm          <= DWELL;
              cnt          <= DW;
              req_ready    <= 1'b0;
              dwell_active <= 1'b1;
            end
          end
        end
        DWELL: begin
          if (clk_en) begin
            if (cnt <= 1) begin
              fsm          <= IDLE;
              cnt          <= '0;
              req_ready    <= 1'b1;
              dwell_active <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer with a 4-tick dwell.
// Vector table plus hand sequences for hold, reset and wrap cases.
module tb_state_sequencer;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_state = 3'd0;
  logic       req_ready;
  logic [2:0] state_select;
  logic       state_changed;
  logic       req_rejected;
  logic       dwell_active;
`ifdef SEQ_AUTOCYCLE_EN
  logic       auto_en = 1'b0;
`endif

  state_sequencer #(
    .DWELL_TICKS(DT),
    .CNT_W(16),
    .NUM_STATES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .req_valid(req_valid),
    .req_state(req_state),
`ifdef SEQ_AUTOCYCLE_EN
    .auto_en(auto_en),
`endif
    .req_ready(req_ready),
    .state_select(state_select),
    .state_changed(state_changed),
    .req_rejected(req_rejected),
    .dwell_active(dwell_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       chg;
    logic       rej;
    logic       dwl;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic       en;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  vec_t vt[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  task automatic check_pop(input string nm);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, "_qempty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({nm, "_sel"}, state_select, e.sel);
    chk({nm, "_chg"}, state_changed, e.chg);
    chk({nm, "_rej"}, req_rejected, e.rej);
    chk({nm, "_dwl"}, dwell_active, e.dwl);
    chk({nm, "_rdy"}, req_ready, !e.dwl);
  endtask

  // Count strobes until ready returns; bounded.
  task automatic wait_dwell(input string nm, input int exp_n);
    int n = 0;
    while (!req_ready && n < 20) begin
      step(1'b1);
      n++;
    end
    chk({nm, "_strobes"}, n, exp_n);
  endtask

  initial begin
    vt[0] = '{3'd3, 1'b0, '{3'd3, 1'b1, 1'b0, 1'b1}};
    vt[1] = '{3'd3, 1'b0, '{3'd3, 1'b0, 1'b0, 1'b0}};
    vt[2] = '{3'd6, 1'b0, '{3'd3, 1'b0, 1'b1, 1'b0}};
    vt[3] = '{3'd7, 1'b1, '{3'd3, 1'b0, 1'b1, 1'b0}};
    vt[4] = '{3'd0, 1'b0, '{3'd0, 1'b1, 1'b0, 1'b1}};
    vt[5] = '{3'd0, 1'b0, '{3'd0, 1'b0, 1'b0, 1'b0}};
    vt[6] = '{3'd4, 1'b1, '{3'd4, 1'b1, 1'b0, 1'b1}};
    vt[7] = '{3'd5, 1'b0, '{3'd4, 1'b0, 1'b1, 1'b0}};
    vt[8] = '{3'd1, 1'b0, '{3'd1, 1'b1, 1'b0, 1'b1}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", state_select, 0);
    chk("rst_rdy", req_ready, 1);
    chk("rst_dwl", dwell_active, 0);
    chk("rst_chg", state_changed, 0);
    chk("rst_rej", req_rejected, 0);
    rst = 1'b0;
    step(1'b0);

    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_state = vt[i].req;
      q.push_back(vt[i].e);
      step(vt[i].en);
      req_valid = 1'b0;
      check_pop($sformatf("vec%0d", i));
      step(1'b0);
      chk($sformatf("vec%0d_pulse", i),
          {state_changed, req_rejected}, 2'b00);
      if (vt[i].e.dwl) wait_dwell($sformatf("vec%0d", i), DT);
    end

    // Request held through a dwell: accepted only after ready returns.
    req_valid = 1'b1;
    req_state = 3'd3;
    q.push_back('{3'd3, 1'b1, 1'b0, 1'b1});
    step(1'b0);
    check_pop("hold_acc");
    req_state = 3'd2;
    for (int i = 0; i < DT - 1; i++) begin
      step(1'b1);
      chk($sformatf("hold_rdy%0d", i), req_ready, 0);
      chk($sformatf("hold_sel%0d", i), state_select, 3);
    end
    step(1'b1);
    chk("hold_exit_rdy", req_ready, 1);
    chk("hold_exit_sel", state_select, 3);
    q.push_back('{3'd2, 1'b1, 1'b0, 1'b1});
    step(1'b0);
    req_valid = 1'b0;
    check_pop("hold_next");
    wait_dwell("hold_next", DT);

    // Asynchronous reset two strobes into a dwell.
    req_valid = 1'b1;
    req_state = 3'd1;
    q.push_back('{3'd1, 1'b1, 1'b0, 1'b1});
    step(1'b0);
    check_pop("rstdw_acc");
    req_state = 3'd3;
    step(1'b1);
    step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstdw_sel", state_select, 0);
    chk("rstdw_rdy", req_ready, 1);
    chk("rstdw_dwl", dwell_active, 0);
    @(posedge clk);
    #1;
    chk("rstdw_hold_sel", state_select, 0);
    req_valid = 1'b0;
    rst = 1'b0;
    step(1'b0);
    chk("rstdw_after_chg", state_changed, 0);

`ifdef SEQ_AUTOCYCLE_EN
    req_valid = 1'b1;
    req_state = 3'd4;
    q.push_back('{3'd4, 1'b1, 1'b0, 1'b1});
    step(1'b0);
    req_valid = 1'b0;
    check_pop("auto_pre");
    wait_dwell("auto_pre", DT);
    auto_en = 1'b1;
    step(1'b0);
    chk("auto_noen_sel", state_select, 4);
    q.push_back('{3'd0, 1'b1, 1'b0, 1'b1});
    step(1'b1);
    auto_en = 1'b0;
    check_pop("auto_wrap");
    wait_dwell("auto_wrap", DT);
`endif

    if (q.size() != 0) chk("queue_left", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
